// File: rtl/calculator_pkg.sv
// Shared calculator constants and the packed-word record carried from the
// result packer's lane assembler to its output holding register.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int RESULT_LANES  = MEM_WORD_SIZE / DATA_W;

    typedef enum logic {
        FILL_LOW_FIRST  = 1'b0,
        FILL_HIGH_FIRST = 1'b1
    } fill_order_e;

    typedef struct packed {
        logic [MEM_WORD_SIZE-1:0] data;
        logic [RESULT_LANES-1:0]  mask;
        logic                     last;
    } packed_word_t;

endpackage

// File: rtl/result_packer_if.sv
// Result-beat input and packed-word output handshakes of the result packer.
// The master drives beats and accepts words; the slave is the packer.
interface result_packer_if #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
);
    localparam int LANES  = MEM_WORD_SIZE / DATA_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [DATA_W-1:0]        res;
    logic                     res_valid;
    logic                     res_last;
    logic                     res_ready;
    logic                     flush;
    logic [MEM_WORD_SIZE-1:0] word;
    logic [LANES-1:0]         word_mask;
    logic                     word_last;
    logic                     word_valid;
    logic                     word_ready;
    logic [LANE_W-1:0]        lane;

    modport master (
        output res, res_valid, res_last, flush, word_ready,
        input  res_ready, word, word_mask, word_last, word_valid, lane
    );

    modport slave (
        input  res, res_valid, res_last, flush, word_ready,
        output res_ready, word, word_mask, word_last, word_valid, lane
    );

endinterface

// File: rtl/packer_out_reg.sv
// Single-entry valid/ready holding register. The held word only changes on a
// load, so it stays stable for as long as the consumer stalls.
module packer_out_reg #(
    parameter type T = calculator_pkg::packed_word_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid,
    input  T     in_word,
    output logic in_ready,
    output logic out_valid,
    output T     out_word,
    input  logic out_ready
);

    logic valid_reg;
    T     word_reg;

    // Free when empty or being drained this cycle, so drain and load can overlap.
    assign in_ready  = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_word  = word_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= 1'b0;
            word_reg  <= '0;
        end else if (in_valid && in_ready) begin
            valid_reg <= 1'b1;
            word_reg  <= in_word;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/result_packer.sv
// Packs DATA_W-wide ALU results into MEM_WORD_SIZE-wide words with an
// auto-advancing lane pointer, early close on last/flush and a lane mask.
module result_packer #(
    parameter int DATA_W        = calculator_pkg::DATA_W,
    parameter int MEM_WORD_SIZE = calculator_pkg::MEM_WORD_SIZE,
    parameter int FILL_ORDER    = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    result_packer_if.slave bus
);
    import calculator_pkg::*;

    localparam int                LANES      = MEM_WORD_SIZE / DATA_W;
    localparam int                LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);
    localparam bit                HIGH_FIRST = (FILL_ORDER == int'(FILL_HIGH_FIRST));

    generate
        if (((MEM_WORD_SIZE % DATA_W) != 0) || (LANES < 2)) begin : g_param_check
            $error("result_packer: MEM_WORD_SIZE must be a multiple of DATA_W giving at least two lanes");
        end
    endgenerate

    typedef struct packed {
        logic [MEM_WORD_SIZE-1:0] data;
        logic [LANES-1:0]         mask;
        logic                     last;
    } word_t;

    logic [MEM_WORD_SIZE-1:0] asm_data_reg, asm_data_next, merged_data;
    logic [LANES-1:0]         asm_mask_reg, asm_mask_next, merged_mask, beat_onehot;
    logic [LANE_W-1:0]        lane_cnt_reg, lane_cnt_next, phys_lane;
    logic                     flush_pend_reg, flush_pend_next;
    logic                     out_free, out_valid;
    logic                     beat_acc, flush_req, beat_closes, flush_emit, load;
    word_t                    load_word, out_word;

    assign bus.res_ready = rst_ni && out_free;
    assign beat_acc      = bus.res_valid && bus.res_ready;
    assign flush_req     = bus.flush || flush_pend_reg;
    assign phys_lane     = HIGH_FIRST ? (LAST_LANE - lane_cnt_reg) : lane_cnt_reg;

    // Merge the accepted beat into its physical lane; other lanes keep assembly.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign beat_onehot[gi] = beat_acc && (phys_lane == LANE_W'(gi));
            assign merged_data[gi*DATA_W +: DATA_W] =
                beat_onehot[gi] ? bus.res : asm_data_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign merged_mask = asm_mask_reg | beat_onehot;

    // A flush riding on an accepted beat closes the word as if res_last were set.
    assign beat_closes = beat_acc && ((lane_cnt_reg == LAST_LANE) || bus.res_last || flush_req);
    assign flush_emit  = !beat_acc && flush_req && (asm_mask_reg != '0) && out_free;
    assign load        = beat_closes || flush_emit;

    assign load_word.data = merged_data;
    assign load_word.mask = merged_mask;
    assign load_word.last = flush_req || bus.res_last;

    always_comb begin
        asm_data_next   = asm_data_reg;
        asm_mask_next   = asm_mask_reg;
        lane_cnt_next   = lane_cnt_reg;
        flush_pend_next = flush_pend_reg;
        if (load) begin
            asm_data_next   = '0;
            asm_mask_next   = '0;
            lane_cnt_next   = '0;
            flush_pend_next = 1'b0;
        end else begin
            if (beat_acc) begin
                asm_data_next = merged_data;
                asm_mask_next = merged_mask;
                lane_cnt_next = lane_cnt_reg + LANE_W'(1);
            end
            // Remember a flush that could not be taken because the output was blocked.
            if (bus.flush && (asm_mask_reg != '0)) begin
                flush_pend_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            asm_data_reg   <= '0;
            asm_mask_reg   <= '0;
            lane_cnt_reg   <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            asm_data_reg   <= asm_data_next;
            asm_mask_reg   <= asm_mask_next;
            lane_cnt_reg   <= lane_cnt_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    packer_out_reg #(
        .T (word_t)
    ) u_out_reg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (load),
        .in_word   (load_word),
        .in_ready  (out_free),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_ready (bus.word_ready)
    );

    assign bus.word       = out_word.data;
    assign bus.word_mask  = out_word.mask;
    assign bus.word_last  = out_word.last;
    assign bus.word_valid = out_valid;
    assign bus.lane       = lane_cnt_reg;

endmodule
